// File: rtl/max_pool_ctrl.sv
// max_pool_ctrl: streams one feature map out of a row-major buffer and emits
// the signed maximum of every POOL x POOL window (stride STRIDE) in raster
// order through a valid/ready output.
// Optional build macro: MAXPOOL_RELU_EN clamps negative maxima to zero (fused ReLU).
module max_pool_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int POOL       = 2,
    parameter int STRIDE     = 2,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int OW  = (IMG_W - POOL) / STRIDE + 1;
    localparam int OH  = (IMG_H - POOL) / STRIDE + 1;
    localparam int KW  = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int OXW = (OW > 1) ? $clog2(OW) : 1;
    localparam int OYW = (OH > 1) ? $clog2(OH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_OUT,
        S_FIN
    } state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         kx_q, kx_d;
    logic [KW-1:0]         ky_q, ky_d;
    logic [OXW-1:0]        ox_q, ox_d;
    logic [OYW-1:0]        oy_q, oy_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  rd_vld_q, rd_vld_d;      // rd_data carries a window word this cycle
    logic                  rd_first_q, rd_first_d;  // that word is the first of its window

    logic [ADDR_WIDTH-1:0] row_addr;
    logic                  last_tap;
    logic                  last_window;

    assign last_tap    = (kx_q == KW'(POOL - 1)) && (ky_q == KW'(POOL - 1));
    assign last_window = (ox_q == OXW'(OW - 1)) && (oy_q == OYW'(OH - 1));

    // State, counters and accumulator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            kx_q       <= '0;
            ky_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            acc_q      <= '0;
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            acc_q      <= acc_d;
            rd_vld_q   <= rd_vld_d;
            rd_first_q <= rd_first_d;
        end
    end

    // Next-state logic, window/tap counters and control outputs
    always_comb begin
        state_d   = state_q;
        kx_d      = kx_q;
        ky_d      = ky_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    kx_d    = '0;
                    ky_d    = '0;
                    ox_d    = '0;
                    oy_d    = '0;
                end
            end
            S_FETCH: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (kx_q == KW'(POOL - 1)) begin
                    kx_d = '0;
                    if (last_tap) begin
                        ky_d    = '0;
                        state_d = S_DRAIN;
                    end else begin
                        ky_d = ky_q + KW'(1);
                    end
                end else begin
                    kx_d = kx_q + KW'(1);
                end
            end
            S_DRAIN: begin
                // the last word of the window is folded into acc this cycle
                busy    = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    if (last_window) begin
                        ox_d    = '0;
                        oy_d    = '0;
                        state_d = S_FIN;
                    end else begin
                        if (ox_q == OXW'(OW - 1)) begin
                            ox_d = '0;
                            oy_d = oy_q + OYW'(1);
                        end else begin
                            ox_d = ox_q + OXW'(1);
                        end
                        state_d = S_FETCH;
                    end
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read address of the current tap; parked at 0 when not fetching
    always_comb begin
        row_addr = ADDR_WIDTH'(oy_q) * ADDR_WIDTH'(STRIDE) + ADDR_WIDTH'(ky_q);
        rd_addr  = '0;
        if (state_q == S_FETCH) begin
            rd_addr = row_addr * ADDR_WIDTH'(IMG_W)
                    + ADDR_WIDTH'(ox_q) * ADDR_WIDTH'(STRIDE) + ADDR_WIDTH'(kx_q);
        end
    end

    // Signed running maximum; first word of a window reloads, ties keep acc
    always_comb begin
        rd_vld_d   = rd_en;
        rd_first_d = rd_en && (kx_q == '0) && (ky_q == '0);
        acc_d      = acc_q;
        if (rd_vld_q) begin
            if (rd_first_q || ($signed(rd_data) > $signed(acc_q))) begin
                acc_d = rd_data;
            end
        end
    end

    // Output word, optionally rectified
    always_comb begin
`ifdef MAXPOOL_RELU_EN
        out_data = acc_q[DATA_WIDTH-1] ? '0 : acc_q;
`else
        out_data = acc_q;
`endif
    end

endmodule

// File: tb/tb_max_pool_ctrl.sv
// tb_max_pool_ctrl: self-checking bench for max_pool_ctrl with an 8x8 map,
// 2x2 windows, stride 2. A window-max reference model predicts every output.
module tb_max_pool_ctrl;

    localparam int DW   = 32;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int P    = 2;
    localparam int S    = 2;
    localparam int AW   = 16;
    localparam int OW   = (W - P) / S + 1;
    localparam int OH   = (H - P) / S + 1;
    localparam int NOUT = OW * OH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, rd_en, out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;

    always #5 clk = ~clk;

    max_pool_ctrl #(
        .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .POOL(P), .STRIDE(S), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    // Feature-map buffer: data returned one cycle after the read strobe
    logic [DW-1:0] mem [W*H];
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: maximum over each window, in raster order
    logic [DW-1:0] exp_q[$];

    function automatic logic [DW-1:0] window_max(input int ox, input int oy);
        logic signed [DW-1:0] best;
        logic signed [DW-1:0] v;
        best = mem[(oy * S) * W + ox * S];
        for (int ky = 0; ky < P; ky++)
            for (int kx = 0; kx < P; kx++) begin
                v = mem[(oy * S + ky) * W + ox * S + kx];
                if (v > best) best = v;
            end
`ifdef MAXPOOL_RELU_EN
        if (best < 0) best = '0;
`endif
        return best;
    endfunction

    task automatic build_expected();
        exp_q.delete();
        for (int oy = 0; oy < OH; oy++)
            for (int ox = 0; ox < OW; ox++)
                exp_q.push_back(window_max(ox, oy));
    endtask

    // Monitor, sampled on the falling edge
    int            cyc = 0;
    int            n_out, done_cnt, first_busy_cyc, done_cyc, last_hs_cyc, first_rd_addr;
    logic [DW-1:0] first_out, last_out;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (busy && first_busy_cyc < 0) first_busy_cyc = cyc;
            if (rd_en && first_rd_addr < 0) first_rd_addr = int'(rd_addr);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid) chk("rd_en_during_out", rd_en, 0);
            if (out_valid && out_ready) begin
                last_hs_cyc = cyc;
                n_out++;
                if (n_out == 1) first_out = out_data;
                last_out = out_data;
                if (exp_q.size() == 0) chk("extra_output", n_out, NOUT);
                else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    $display("out #%0d: data=%0h expected=%0h", n_out, out_data, e);
                    chk("out_data", out_data, e);
                end
            end
        end
    end

    task automatic prep_frame();
        build_expected();
        n_out          = 0;
        done_cnt       = 0;
        first_busy_cyc = -1;
        first_rd_addr  = -1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rand_ready, input bit extra_starts, output bit got);
        got = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = (extra_starts && (c % 7 == 3)) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic finish_frame(input bit rand_ready, input bit extra_starts);
        bit got;
        wait_done(rand_ready, extra_starts, got);
        chk("done_seen", got, 1);
        chk("output_count", n_out, NOUT);
        chk("model_drained", exp_q.size(), 0);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic run_frame(input bit rand_ready, input bit extra_starts);
        prep_frame();
        out_ready = 1'b1;
        pulse_start();
        finish_frame(rand_ready, extra_starts);
    endtask

    task automatic random_map();
        for (int i = 0; i < W * H; i++) mem[i] = $urandom;
    endtask

    typedef struct {
        logic [DW-1:0] px0, px1, px2, px3;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit            reached;
        logic [DW-1:0] held;
        int            d0;

        // px0..px3 land on (0,0),(1,0),(0,1),(1,1) of window 0
        vecs[0] = '{32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'hFFFF_FFF7, 32'hFFFF_FFF9, 32'hFFFF_FFFD};
        vecs[1] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        vecs[2] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004, 32'h0000_0004};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        vecs[4] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
`ifdef MAXPOOL_RELU_EN
        vecs[0].exp = '0;
        vecs[3].exp = '0;
`endif

        // Reset state, with start held high alongside reset
        rst = 1'b1; start = 1'b1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_rst", busy, 0);

        // Ramp image: pixel(i)=i, continuous ready, timing checks
        for (int i = 0; i < W * H; i++) mem[i] = DW'(i);
        run_frame(0, 0);
        chk("ramp_first_out", first_out, 9);
        chk("ramp_last_out", last_out, 63);
        chk("ramp_busy_to_done", done_cyc - first_busy_cyc, NOUT * (P * P + 2));
        chk("ramp_hs_to_done", done_cyc - last_hs_cyc, 1);
        chk("ramp_done_pulses", done_cnt, 1);
        chk("ramp_first_addr", first_rd_addr, 0);

        // Table vectors placed into window 0
        for (int i = 0; i < 5; i++) begin
            random_map();
            mem[0] = vecs[i].px0; mem[1] = vecs[i].px1;
            mem[W] = vecs[i].px2; mem[W+1] = vecs[i].px3;
            run_frame(1, 0);
            $display("vector %0d: first out=%0h expected=%0h", i, first_out, vecs[i].exp);
            chk("vec_first_out", first_out, vecs[i].exp);
        end

        // Backpressure on the first output
        random_map();
        prep_frame();
        out_ready = 1'b0;
        pulse_start();
        reached = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (out_valid) begin reached = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("bp_valid_reached", reached, 1);
        held = out_data;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("bp_valid_held", out_valid, 1);
            chk("bp_data_stable", out_data, held);
            chk("bp_no_read", rd_en, 0);
        end
        finish_frame(0, 0);

        // Reset while fetching window 3
        random_map();
        prep_frame();
        out_ready = 1'b1;
        pulse_start();
        reached = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (n_out == 2 && rd_en) begin reached = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("rst_mid_reached", reached, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_rd_en", rd_en, 0);
        d0 = done_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid_no_done", done_cnt, d0);
        run_frame(0, 0);
        chk("restart_first_addr", first_rd_addr, 0);

        // Extra start pulses while busy are ignored
        random_map();
        run_frame(1, 1);
        chk("extra_start_done_pulses", done_cnt, 1);

        // Random maps, random backpressure
        for (int r = 0; r < 3; r++) begin
            random_map();
            run_frame(1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/max_pool_ctrl.md
MAX_POOL_CTRL -- requirements
Module: max_pool_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of one pixel word, signed two's complement.
REQ-002 Parameter IMG_W, default 8: input feature-map width in pixels.
REQ-003 Parameter IMG_H, default 8: input feature-map height in pixels.
REQ-004 Parameter POOL, default 2: square window side (window is POOL x POOL).
REQ-005 Parameter STRIDE, default 2: window step in x and y.
REQ-006 Parameter ADDR_WIDTH, default 16: read address width.
REQ-007 Port clk, input, 1: single clock; all logic on rising edge.
REQ-008 Port rst, input, 1: synchronous, active-high reset.
REQ-009 Port start, input, 1: one-cycle request to pool one full feature map.
REQ-010 Port busy, output, 1: high from the cycle after an accepted start until done.
REQ-011 Port done, output, 1: one-cycle pulse after the last output handshake.
REQ-012 Port rd_en, output, 1: read strobe to the feature-map buffer.
REQ-013 Port rd_addr, output, ADDR_WIDTH: row-major pixel address, y*IMG_W + x.
REQ-014 Port rd_data, input, DATA_WIDTH: buffer data, valid exactly 1 cycle after rd_en.
REQ-015 Port out_data, output, DATA_WIDTH: pooled maximum of the current window.
REQ-016 Port out_valid, output, 1: out_data valid.
REQ-017 Port out_ready, input, 1: downstream accepts out_data.

Function
REQ-018 The block SHALL produce OW*OH outputs, OW=(IMG_W-POOL)/STRIDE+1, OH=(IMG_H-POOL)/STRIDE+1, in raster order (ox fastest).
REQ-019 States SHALL be IDLE, FETCH, DRAIN, OUT, FIN.
REQ-020 IDLE: start=1 -> FETCH with ox=oy=kx=ky=0; start while not IDLE SHALL be ignored.
REQ-021 FETCH: one read per cycle, rd_en=1, rd_addr=(oy*STRIDE+ky)*IMG_W + ox*STRIDE+kx, kx fastest; after read POOL*POOL-1 -> DRAIN.
REQ-022 Accumulator: first returned window word loads acc; each later word sets acc = max(acc, word) using a signed compare; on ties acc keeps its value.
REQ-023 DRAIN (1 cycle): last word folded into acc -> OUT; rd_en=0.
REQ-024 OUT: out_valid=1, out_data=acc held stable until out_valid&&out_ready; no reads issued while in OUT.
REQ-025 On handshake: if last window -> FIN, else advance ox (wrap to 0 and increment oy at OW-1) -> FETCH in the next cycle.
REQ-026 FIN: done=1 for exactly one cycle, busy=0 -> IDLE.
REQ-027 Minimum window period SHALL be POOL*POOL+2 cycles (fetch + drain + 1 OUT cycle with out_ready=1).
REQ-028 out_ready high outside OUT SHALL have no effect; out_valid SHALL NOT drop before a handshake.

Reset
REQ-029 rst=1 SHALL force IDLE at the next edge from any state, aborting any frame, with no done pulse.
REQ-030 Reset values: busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_data=0, acc and all counters 0.
REQ-031 rst and start both high in the same cycle: rst wins.

Configuration
REQ-032 Macro MAXPOOL_RELU_EN defined: out_data = (acc<0) ? 0 : acc (fused ReLU).
REQ-033 MAXPOOL_RELU_EN undefined: out_data = acc unmodified; negative maxima pass through.

Verification
REQ-034 8x8 map, pixel(i)=i, POOL=2, STRIDE=2, out_ready=1 -> 16 outputs 9,11,13,15,25,...,63, done 1 cycle after last, 16*6=96 cycles after start.
REQ-035 Window {-5,-3,-9,-7} -> out_data=-3 without macro; 0 with MAXPOOL_RELU_EN.
REQ-036 out_ready held low 10 cycles at first output -> out_valid stays high, out_data stable, rd_en=0 throughout.
REQ-037 rst pulsed in FETCH of window 3 -> next cycle busy=0, out_valid=0, no done; new start restarts at rd_addr=0.
REQ-038 start pulsed again while busy -> ignored, output count stays 16.
REQ-039 Window {0x7FFFFFFF, 0x80000000, 1, 0x7FFFFFFF} -> out_data=0x7FFFFFFF (signed compare, tie kept).
